// File: rtl/pc_branch_ctrl_pkg.sv
// Shared types and constants for the PC / branch controller.
// HALT exists only when BRANCH_ALIGN_CHECK_EN is defined.
package pc_branch_ctrl_pkg;

    localparam int PC_W = 12;
    localparam logic [PC_W-1:0] RESET_PC_DEF = 12'h000;
    localparam logic [7:0] TAKEN_MAX = 8'hFF;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_RESOLVE = 2'd1,
        S_FLUSH   = 2'd2
`ifdef BRANCH_ALIGN_CHECK_EN
        ,
        S_HALT    = 2'd3
`endif
    } state_t;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC 2:1 mux: 0 selects the sequential PC, 1 the branch target.
module pc_next_mux
    import pc_branch_ctrl_pkg::*;
(
    input  logic [PC_W-1:0] seq_pc,
    input  logic [PC_W-1:0] target,
    input  logic            select,
    output logic [PC_W-1:0] next_pc
);

    assign next_pc = select ? target : seq_pc;

endmodule

// File: rtl/pc_branch_ctrl.sv
// PC register with a RUN/RESOLVE/FLUSH branch FSM and taken counter.
// Optional BRANCH_ALIGN_CHECK_EN halts on misaligned taken targets.
module pc_branch_ctrl
    import pc_branch_ctrl_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter int              PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Stall,
    input  logic            Branch,
    input  logic            BrCond,
    input  logic [PC_W-1:0] AddALUOut,
    output logic [PC_W-1:0] PC,
    output logic            Select,
    output logic            Flush,
    output logic            FetchValid,
    output logic [7:0]      TakenCount
`ifdef BRANCH_ALIGN_CHECK_EN
    ,
    output logic            MisalignErr
`endif
);

    state_t          state, state_d;
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] mux_pc;
    logic            load_pc;
    logic            taken;
    logic            misalign;

    assign seq_pc = PC + PC_W'(PC_STEP);
    assign taken  = (state == S_RESOLVE) && BrCond && !Stall;

`ifdef BRANCH_ALIGN_CHECK_EN
    assign misalign = taken && (AddALUOut[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    pc_next_mux u_mux (
        .seq_pc  (seq_pc),
        .target  (AddALUOut),
        .select  (Select),
        .next_pc (mux_pc)
    );

    always_comb begin
        state_d    = state;
        Select     = 1'b0;
        Flush      = 1'b0;
        FetchValid = 1'b0;
        load_pc    = 1'b0;
        unique case (state)
            S_RUN: begin
                FetchValid = 1'b1;
                if (!Stall) begin
                    load_pc = 1'b1;
                    state_d = Branch ? S_RESOLVE : S_RUN;
                end
            end
            S_RESOLVE: begin
                FetchValid = 1'b1;
                if (!Stall) begin
                    if (misalign) begin
                        Flush = 1'b1;
`ifdef BRANCH_ALIGN_CHECK_EN
                        state_d = S_HALT;
`endif
                    end else if (BrCond) begin
                        Select  = 1'b1;
                        Flush   = 1'b1;
                        load_pc = 1'b1;
                        state_d = S_FLUSH;
                    end else begin
                        load_pc = 1'b1;
                        state_d = S_RUN;
                    end
                end
            end
            S_FLUSH: begin
                if (!Stall) state_d = S_RUN;
            end
`ifdef BRANCH_ALIGN_CHECK_EN
            S_HALT: begin
                state_d = S_HALT;
            end
`endif
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_RUN;
            PC         <= RESET_PC;
            TakenCount <= 8'h00;
        end else begin
            state <= state_d;
            if (load_pc) PC <= mux_pc;
            if (Select && TakenCount != TAKEN_MAX)
                TakenCount <= TakenCount + 8'h01;
        end
    end

`ifdef BRANCH_ALIGN_CHECK_EN
    // Sticky until reset; HALT keeps the bad target from ever loading.
    always_ff @(posedge clk) begin
        if (reset)         MisalignErr <= 1'b0;
        else if (misalign) MisalignErr <= 1'b1;
    end
`endif

endmodule

// File: doc/pc_branch_ctrl.md
PC_BRANCH_CTRL -- requirements
Module: pc_branch_ctrl

Interface
REQ-001 RESET_PC, 12'h000, value loaded into PC on reset, SHALL be a parameter.
REQ-002 PC_STEP, 4, sequential increment, SHALL be a parameter.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 Stall  input  1  freezes all state when high.
REQ-006 Branch  input  1  decoded branch in the current fetch slot.
REQ-007 BrCond  input  1  branch condition from the ALU, valid only in RESOLVE.
REQ-008 AddALUOut  input  12  branch target address.
REQ-009 PC  output  12  registered program counter.
REQ-010 Select  output  1  next-PC select: 0 = PC+PC_STEP, 1 = AddALUOut.
REQ-011 Flush  output  1  squash the wrong-path instruction, one-cycle pulse.
REQ-012 FetchValid  output  1  current fetch is on the valid path.
REQ-013 TakenCount  output  8  count of taken branches.
REQ-014 MisalignErr  output  1  sticky misaligned-target flag; SHALL exist only under BRANCH_ALIGN_CHECK_EN.

Function
REQ-015 FSM states SHALL be RUN, RESOLVE and FLUSH, plus HALT under BRANCH_ALIGN_CHECK_EN.
REQ-016 RUN with Stall=0: PC <= PC+PC_STEP; if Branch=1, next state SHALL be RESOLVE, else RUN.
REQ-017 RESOLVE with Stall=0 and BrCond=1: Select=1, Flush=1, PC <= AddALUOut, TakenCount increments, next state SHALL be FLUSH.
REQ-018 RESOLVE with Stall=0 and BrCond=0: Select=0, PC <= PC+PC_STEP, next state SHALL be RUN.
REQ-019 FLUSH SHALL last one cycle with FetchValid=0 and PC held, then go to RUN; Stall SHALL extend FLUSH.
REQ-020 Select and Flush SHALL be combinational from state, BrCond and Stall, and SHALL be 0 in every other case.
REQ-021 FetchValid SHALL be 1 in RUN and RESOLVE, and 0 in FLUSH and HALT.
REQ-022 Stall=1 SHALL hold PC, state and TakenCount, and force Select=0 and Flush=0; Branch is not captured while stalled.
REQ-023 Branch asserted in RESOLVE or FLUSH SHALL be ignored; at most one branch is outstanding.
REQ-024 PC arithmetic SHALL be modulo 2^12: PC 12'hFFC + 4 SHALL give 12'h000 with no flag.
REQ-025 TakenCount SHALL saturate at 8'hFF.
REQ-026 Redirect latency: the target SHALL appear on PC one cycle after the RESOLVE cycle with BrCond=1.

Reset
REQ-027 reset=1 SHALL set PC=RESET_PC, state=RUN, TakenCount=0 and MisalignErr=0, giving Select=0, Flush=0 and FetchValid=1.
REQ-028 reset SHALL take priority over Stall; reset in RESOLVE or FLUSH SHALL abandon the branch without incrementing TakenCount.

Configuration
REQ-029 With BRANCH_ALIGN_CHECK_EN defined, a taken branch with AddALUOut[1:0]!=0 SHALL NOT redirect.
  - MisalignErr SHALL be set sticky.
  - Flush SHALL be 1 for that cycle.
  - The FSM SHALL enter HALT, with PC frozen until reset.
  - TakenCount SHALL NOT increment.
REQ-030 Without BRANCH_ALIGN_CHECK_EN, the target SHALL be used unmodified, and the HALT state and MisalignErr port SHALL be absent.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, the PC width constant (12) and the reset PC default.
REQ-032 The next-PC 2:1 mux SHALL be a sub-module pc_next_mux (12-bit, select-driven); all other logic SHALL be in pc_branch_ctrl.

Verification
REQ-033 Reset, then 3 unstalled cycles with Branch=0 -> PC sequence 000, 004, 008, 00C; Select=0; FetchValid=1.
REQ-034 Branch=1 at PC=008, then BrCond=1 with AddALUOut=12'h0F0:
  - RESOLVE cycle: Select=1, Flush=1.
  - Next cycle: PC=0F0, FetchValid=0 for one cycle.
  - TakenCount=1.
REQ-035 Branch=1, then BrCond=0 -> Select=0, Flush=0, PC advances by 4, TakenCount unchanged.
REQ-036 Stall=1 for 2 cycles during RESOLVE with BrCond=1 -> PC, state and outputs held; redirect occurs in the first unstalled cycle.
REQ-037 PC at 12'hFFC with no branch -> PC=000; reset asserted during FLUSH -> PC=RESET_PC, state RUN, next cycle.
REQ-038 With BRANCH_ALIGN_CHECK_EN, taken branch to 12'h0F2 -> MisalignErr=1, PC frozen, FetchValid=0 until reset.
